mul_sign_frontend: RTL and testbench
====================================

Name: mul_sign_frontend

Overview:
- Control and sign-handling stage between the EX-stage M-extension issue logic and the unsigned shift-add multiplier core.
- Accepts MUL/MULH/MULHSU/MULHU requests and converts the operands to magnitudes.
- Drives the core's start/ready/done handshake, then applies sign correction and half-selection to the 64-bit product.
- Holds the 32-bit result until the pipeline accepts it.

Parameters:
- WIDTH, 32, operand width; must equal the multiplier core's operand width.
- TIMEOUT_CYCLES, 2*WIDTH+8, core-wait watchdog limit in cycles.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- req_valid_i  in  1  request present from EX
- req_ready_o  out  1  block can accept a request
- req_funct3_i  in  3  RV32M funct3; only 000..011 are accepted
- req_rs1_i  in  WIDTH  operand A
- req_rs2_i  in  WIDTH  operand B
- flush_i  in  1  pipeline flush; aborts the in-flight op
- resp_valid_o  out  1  result available
- resp_ready_i  in  1  pipeline consumes the result
- resp_data_o  out  WIDTH  result
- resp_err_o  out  1  watchdog expired; resp_data_o = 0
- mul_reset_n_o  out  1  core reset (active-low)
- mul_start_o  out  1  core start pulse
- mul_multiplicand_o  out  WIDTH  magnitude of A
- mul_multiplier_o  out  WIDTH  magnitude of B
- mul_ready_i  in  1  core idle
- mul_done_i  in  1  core finished
- mul_product_i  in  2*WIDTH  unsigned core product

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready_o=1, resp_valid_o=0, resp_data_o=0, resp_err_o=0.
  - mul_reset_n_o=0 while rst is high, then 1.
  - mul_start_o=0, operand outputs 0.
- States: IDLE, ISSUE, WAIT, FIXUP, RESP.
- IDLE:
  - req_ready_o = 1 only when req_funct3_i[2]==0. Division requests are never accepted by this block.
  - On req_valid_i && req_ready_o, register:
    - sa = rs1[MSB] if funct3 is 001 or 010, else 0.
    - sb = rs2[MSB] if funct3 is 001, else 0.
    - Magnitudes |A|, |B|. Two's-complement negate when the corresponding sign flag is set; 0x80000000 stays 0x80000000 as unsigned.
    - neg = sa^sb, and funct3.
  - Go to ISSUE.
- ISSUE:
  - Wait for mul_ready_i.
  - Assert mul_start_o for exactly one cycle with the operands stable, then go to WAIT.
  - Operands are held stable until FIXUP.
- WAIT:
  - Go to FIXUP on mul_done_i.
  - A watchdog counter starts at 0 on entry to ISSUE. When it reaches TIMEOUT_CYCLES, go to RESP with resp_err_o=1 and data 0.
- FIXUP (1 cycle):
  - p = neg ? -mul_product_i : mul_product_i, computed in 2*WIDTH bits.
  - funct3 000 selects p[WIDTH-1:0]; all others select p[2*WIDTH-1:WIDTH].
  - Register the selection into resp_data_o and go to RESP.
- RESP:
  - resp_valid_o=1 with data and err stable until resp_ready_i.
  - On the acceptance cycle go to IDLE. resp_valid_o drops and err clears the next cycle.
  - req_ready_o=0, so there is no back-to-back overlap.
- Latency: accept to resp_valid_o is 1 (ISSUE) + core latency + 1 (FIXUP), minimum 3 cycles when mul_ready_i is already high.
- flush_i (any state except IDLE):
  - Next state IDLE and resp_valid_o=0.
  - mul_reset_n_o low for exactly one cycle if the state was ISSUE or WAIT.
  - Any pending response is discarded.
  - flush_i in IDLE alongside req_valid_i suppresses acceptance.
- flush_i together with resp_ready_i in RESP: flush wins; the result is dropped.
- mul_done_i outside WAIT is ignored.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- With the macro defined: if either operand is 0 at acceptance, skip ISSUE/WAIT/FIXUP. Go directly to RESP with data 0 one cycle after acceptance; the core is not started.
- Without the macro: every accepted op goes through the core, including zero operands.

Decomposition:
- The shared mult_types package gains:
  - enum mfe_state_e {IDLE, ISSUE, WAIT, FIXUP, RESP}.
  - enum mul_op_e {MUL=3'b000, MULH=3'b001, MULHSU=3'b010, MULHU=3'b011}.
  - Packed struct mfe_req_s holding sa, sb, neg, op and the two magnitudes.
  - Constant MFE_TIMEOUT_DEFAULT.
- Sub-module: mul_sign_fixup is combinational and holds the magnitude conversion plus product negate/half-select. The FSM stays in the top module.

Test Plan:
- MUL, rs1=7, rs2=-3 (0xFFFFFFFD), core returns 0x15 -> resp_data_o=0xFFFFFFEB, mul_multiplicand_o=7, mul_multiplier_o=3.
- MULH, rs1=0x80000000, rs2=0x80000000 -> core operands 0x80000000/0x80000000, resp_data_o=0x40000000.
- MULHSU, rs1=-1, rs2=0xFFFFFFFF -> resp_data_o=0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
- resp_ready_i held low 10 cycles after MULHU 0x10000 x 0x10000 -> resp_valid_o stays high and resp_data_o=1 stable; req_ready_o=0 throughout.
- flush_i in WAIT -> IDLE next cycle, mul_reset_n_o low 1 cycle, no resp_valid_o; a following MUL 2x3 returns 6.
- Core stub never asserts mul_done_i -> resp_err_o=1, resp_data_o=0 after TIMEOUT_CYCLES. With MUL_ZERO_BYPASS_EN, MUL 0 x 5 -> resp_valid_o one cycle after accept, data 0, mul_start_o never pulsed.

Source files
------------

// File: rtl/mul_sign_frontend_pkg.sv
// mult_types: shared types and constants for the M-extension multiply frontend.
// Holds the FSM state, RV32M multiply opcodes and the captured request record.
package mult_types;

    localparam int MFE_WIDTH           = 32;
    localparam int MFE_TIMEOUT_DEFAULT = 2 * MFE_WIDTH + 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIXUP,
        RESP
    } mfe_state_e;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mul_op_e;

    typedef struct packed {
        logic                 sa;
        logic                 sb;
        logic                 neg;
        mul_op_e              op;
        logic [MFE_WIDTH-1:0] mag_a;
        logic [MFE_WIDTH-1:0] mag_b;
    } mfe_req_s;

endpackage

// File: rtl/mul_sign_frontend_if.sv
// mul_sign_frontend_if: EX-stage request/response and multiplier-core handshake bundle.
// The frontend connects through the slave modport; its environment uses master.
interface mul_sign_frontend_if #(
    parameter int WIDTH = 32
);
    logic               req_valid_i;
    logic               req_ready_o;
    logic [2:0]         req_funct3_i;
    logic [WIDTH-1:0]   req_rs1_i;
    logic [WIDTH-1:0]   req_rs2_i;
    logic               flush_i;
    logic               resp_valid_o;
    logic               resp_ready_i;
    logic [WIDTH-1:0]   resp_data_o;
    logic               resp_err_o;
    logic               mul_reset_n_o;
    logic               mul_start_o;
    logic [WIDTH-1:0]   mul_multiplicand_o;
    logic [WIDTH-1:0]   mul_multiplier_o;
    logic               mul_ready_i;
    logic               mul_done_i;
    logic [2*WIDTH-1:0] mul_product_i;

    modport slave (
        input  req_valid_i, req_funct3_i, req_rs1_i, req_rs2_i, flush_i, resp_ready_i,
        input  mul_ready_i, mul_done_i, mul_product_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        output mul_reset_n_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o
    );

    modport master (
        output req_valid_i, req_funct3_i, req_rs1_i, req_rs2_i, flush_i, resp_ready_i,
        output mul_ready_i, mul_done_i, mul_product_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        input  mul_reset_n_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o
    );

endinterface

// File: rtl/mul_sign_frontend_fixup.sv
// mul_sign_fixup: combinational operand-to-magnitude conversion and product sign/half select.
// Operand side works on the live request; product side on the captured request state.
module mul_sign_fixup
    import mult_types::*;
#(
    parameter int WIDTH = MFE_WIDTH
) (
    input  logic [2:0]         funct3_i,
    input  logic [WIDTH-1:0]   rs1_i,
    input  logic [WIDTH-1:0]   rs2_i,
    output logic               sa_o,
    output logic               sb_o,
    output logic [WIDTH-1:0]   mag_a_o,
    output logic [WIDTH-1:0]   mag_b_o,
    input  logic               neg_i,
    input  mul_op_e            op_i,
    input  logic [2*WIDTH-1:0] product_i,
    output logic [WIDTH-1:0]   result_o
);
    logic [2*WIDTH-1:0] prod_signed;

    always_comb begin
        sa_o    = rs1_i[WIDTH-1] && ((funct3_i == MULH) || (funct3_i == MULHSU));
        sb_o    = rs2_i[WIDTH-1] && (funct3_i == MULH);
        // The most negative operand negates to itself, which is its correct unsigned magnitude.
        mag_a_o = sa_o ? ({WIDTH{1'b0}} - rs1_i) : rs1_i;
        mag_b_o = sb_o ? ({WIDTH{1'b0}} - rs2_i) : rs2_i;

        prod_signed = neg_i ? ({(2*WIDTH){1'b0}} - product_i) : product_i;
        result_o    = (op_i == MUL) ? prod_signed[WIDTH-1:0] : prod_signed[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/mul_sign_frontend.sv
// mul_sign_frontend: sign handling and start/done control in front of the unsigned multiplier core.
// Define MUL_ZERO_BYPASS_EN to answer zero-operand requests directly without starting the core.
module mul_sign_frontend
    import mult_types::*;
#(
    parameter int WIDTH          = MFE_WIDTH,
    parameter int TIMEOUT_CYCLES = 2 * WIDTH + 8
) (
    input logic                clk,
    input logic                rst,
    mul_sign_frontend_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    mfe_state_e       state_q, state_d;
    mfe_req_s         req_q, req_d;
    logic             start_q, start_d;
    logic             mul_rst_n_q, mul_rst_n_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    logic             fix_sa, fix_sb;
    logic [WIDTH-1:0] fix_mag_a, fix_mag_b, fix_result;
    logic             req_ready, accept, bypass, wdog_expired;
    logic             unused_sign_bits;

    mul_sign_fixup #(.WIDTH(WIDTH)) u_fixup (
        .funct3_i  (bus.req_funct3_i),
        .rs1_i     (bus.req_rs1_i),
        .rs2_i     (bus.req_rs2_i),
        .sa_o      (fix_sa),
        .sb_o      (fix_sb),
        .mag_a_o   (fix_mag_a),
        .mag_b_o   (fix_mag_b),
        .neg_i     (req_q.neg),
        .op_i      (req_q.op),
        .product_i (bus.mul_product_i),
        .result_o  (fix_result)
    );

`ifdef MUL_ZERO_BYPASS_EN
    assign bypass = (bus.req_rs1_i == '0) || (bus.req_rs2_i == '0);
`else
    assign bypass = 1'b0;
`endif

    // Division encodings (funct3[2]=1) belong to another unit and are never accepted here.
    assign req_ready    = (state_q == IDLE) && !bus.req_funct3_i[2];
    assign accept       = bus.req_valid_i && req_ready && !bus.flush_i;
    assign wdog_expired = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
    // Individual sign flags are retained for debug visibility; the negate decision uses neg.
    assign unused_sign_bits = req_q.sa ^ req_q.sb;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case can infer a latch.
        state_d      = state_q;
        req_d        = req_q;
        start_d      = 1'b0;
        mul_rst_n_d  = 1'b1;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        wdog_d       = wdog_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.sa    = fix_sa;
                    req_d.sb    = fix_sb;
                    req_d.neg   = fix_sa ^ fix_sb;
                    req_d.op    = mul_op_e'(bus.req_funct3_i);
                    req_d.mag_a = fix_mag_a;
                    req_d.mag_b = fix_mag_b;
                    wdog_d      = '0;
                    if (bypass) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = '0;
                    end else begin
                        state_d = ISSUE;
                        start_d = bus.mul_ready_i;
                    end
                end
            end
            ISSUE: begin
                wdog_d = wdog_q + WD_W'(1);
                if (wdog_expired) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                end else if (start_q) begin
                    state_d = WAIT;
                end else if (bus.mul_ready_i) begin
                    start_d = 1'b1;
                end
            end
            WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                if (bus.mul_done_i) begin
                    state_d = FIXUP;
                end else if (wdog_expired) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                end
            end
            FIXUP: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_data_d  = fix_result;
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything, including a simultaneous response acceptance.
        if (bus.flush_i && (state_q != IDLE)) begin
            state_d      = IDLE;
            start_d      = 1'b0;
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
            if ((state_q == ISSUE) || (state_q == WAIT)) begin
                mul_rst_n_d = 1'b0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            start_q      <= 1'b0;
            mul_rst_n_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            start_q      <= start_d;
            mul_rst_n_q  <= mul_rst_n_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            wdog_q       <= wdog_d;
        end
    end

    assign bus.req_ready_o        = req_ready;
    assign bus.resp_valid_o       = resp_valid_q;
    assign bus.resp_data_o        = resp_data_q;
    assign bus.resp_err_o         = resp_err_q;
    assign bus.mul_reset_n_o      = mul_rst_n_q;
    assign bus.mul_start_o        = start_q;
    assign bus.mul_multiplicand_o = req_q.mag_a;
    assign bus.mul_multiplier_o   = req_q.mag_b;

endmodule

// File: tb/tb_mul_sign_frontend.sv
// tb_mul_sign_frontend: randomized and directed checks of mul_sign_frontend against an
// arithmetic reference model, with a latency-configurable multiplier core stub.
module tb_mul_sign_frontend;
    localparam int W = 32;
    localparam int T = 2 * W + 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mul_sign_frontend_if #(.WIDTH(W)) bus ();

    mul_sign_frontend #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Core stub: captures operands on start, answers with done after stub_lat cycles.
    logic        stub_busy;
    logic        stub_done;
    logic [63:0] stub_prod;
    int          stub_cnt;
    int          stub_lat;
    logic        stub_hang;
    logic        stub_clear;
    logic        stub_ready_en;

    assign bus.mul_ready_i   = !stub_busy && stub_ready_en;
    assign bus.mul_done_i    = stub_done;
    assign bus.mul_product_i = stub_prod;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
            stub_prod <= '0;
            stub_cnt  <= 0;
        end else if (!bus.mul_reset_n_o || stub_clear) begin
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (bus.mul_start_o && !stub_busy) begin
                stub_prod <= {32'b0, bus.mul_multiplicand_o} * {32'b0, bus.mul_multiplier_o};
                if (stub_hang) begin
                    stub_busy <= 1'b1;
                end else if (stub_lat <= 1) begin
                    stub_done <= 1'b1;
                end else begin
                    stub_busy <= 1'b1;
                    stub_cnt  <= stub_lat - 1;
                end
            end else if (stub_busy && !stub_hang) begin
                if (stub_cnt <= 1) begin
                    stub_done <= 1'b1;
                    stub_busy <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact signed/unsigned product, then the half the opcode asks for.
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0]  xa;
        logic signed [65:0]  xb;
        logic signed [131:0] p;
        xa = (f3 == 3'd1 || f3 == 3'd2) ? 66'($signed(a)) : 66'(a);
        xb = (f3 == 3'd1) ? 66'($signed(b)) : 66'(b);
        p  = xa * xb;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.req_funct3_i = f3;
        bus.req_rs1_i    = a;
        bus.req_rs2_i    = b;
        bus.req_valid_i  = 1'b1;
        #1;
        check("req_ready_idle", bus.req_ready_o, 1'b1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int hold, input int slack);
        logic [31:0] exp_data;
        logic [31:0] exp_ma;
        logic [31:0] exp_mb;
        bit          sa;
        bit          sb;
        bit          bypass;
        int          cycles;
        int          starts;
        exp_data = ref_mul(f3, a, b);
        sa       = (f3 == 3'd1 || f3 == 3'd2) && a[31];
        sb       = (f3 == 3'd1) && b[31];
        exp_ma   = sa ? (32'd0 - a) : a;
        exp_mb   = sb ? (32'd0 - b) : b;
        bypass   = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
        bypass = (a == 0) || (b == 0);
`endif
        stub_lat = lat;
        send_req(f3, a, b);
        cycles = 1;
        starts = 0;
        while (!bus.resp_valid_o && cycles < 300) begin
            if (bus.mul_start_o) begin
                starts++;
                check("operand_a", bus.mul_multiplicand_o, exp_ma);
                check("operand_b", bus.mul_multiplier_o, exp_mb);
            end
            @(negedge clk);
            cycles++;
        end
        check("resp_valid", bus.resp_valid_o, 1'b1);
        check("resp_data", bus.resp_data_o, exp_data);
        check("resp_err", bus.resp_err_o, 1'b0);
        check("start_pulses", starts, bypass ? 0 : 1);
        if (bypass) check("bypass_latency", cycles, 1);
        else check("latency_in_range", (cycles >= 3) && (cycles <= lat + 4 + slack), 1'b1);
        check("req_ready_busy", bus.req_ready_o, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.resp_valid_o, 1'b1);
            check("hold_data", bus.resp_data_o, exp_data);
            check("hold_req_ready", bus.req_ready_o, 1'b0);
        end
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        check("resp_dropped", bus.resp_valid_o, 1'b0);
        check("err_clear", bus.resp_err_o, 1'b0);
        check("back_to_idle", bus.req_ready_o, 1'b1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int  cycles;
        bit  seen;
        total            = 0;
        bad              = 0;
        clk              = 1'b0;
        rst              = 1'b0;
        stub_lat         = 1;
        stub_hang        = 1'b0;
        stub_clear       = 1'b0;
        stub_ready_en    = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_rs1_i    = '0;
        bus.req_rs2_i    = '0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b0;
        #1 rst = 1'b1;
        #12;
        check("rst_req_ready", bus.req_ready_o, 1'b1);
        check("rst_resp_valid", bus.resp_valid_o, 1'b0);
        check("rst_resp_data", bus.resp_data_o, 32'h0);
        check("rst_resp_err", bus.resp_err_o, 1'b0);
        check("rst_core_rstn", bus.mul_reset_n_o, 1'b0);
        check("rst_start", bus.mul_start_o, 1'b0);
        check("rst_operand_a", bus.mul_multiplicand_o, 32'h0);
        check("rst_operand_b", bus.mul_multiplier_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("core_rstn_released", bus.mul_reset_n_o, 1'b1);

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1, 0, 0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 3, 0, 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);
        run_op(3'b011, 32'h0001_0000, 32'h0001_0000, 3, 10, 0);
        run_op(3'b000, 32'd0, 32'd5, 2, 0, 0);

        // Division encodings are refused.
        @(negedge clk);
        bus.req_funct3_i = 3'b100;
        bus.req_rs1_i    = 32'd9;
        bus.req_rs2_i    = 32'd3;
        bus.req_valid_i  = 1'b1;
        #1;
        check("div_not_ready", bus.req_ready_o, 1'b0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mul_start_o || bus.resp_valid_o) seen = 1'b1;
        end
        bus.req_valid_i  = 1'b0;
        bus.req_funct3_i = 3'b000;
        check("div_ignored", seen, 1'b0);

        // Flush alongside a valid request in IDLE suppresses acceptance.
        @(negedge clk);
        bus.req_rs1_i   = 32'd5;
        bus.req_rs2_i   = 32'd6;
        bus.req_valid_i = 1'b1;
        bus.flush_i     = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
        check("idle_flush_still_idle", bus.req_ready_o, 1'b1);
        seen = 1'b0;
        repeat (8) begin
            if (bus.mul_start_o || bus.resp_valid_o) seen = 1'b1;
            @(negedge clk);
        end
        check("idle_flush_no_op", seen, 1'b0);

        // Flush while waiting on the core.
        stub_lat = 20;
        send_req(3'b000, 32'd9, 32'd9);
        @(negedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("wait_flush_idle", bus.req_ready_o, 1'b1);
        check("wait_flush_core_rstn_low", bus.mul_reset_n_o, 1'b0);
        check("wait_flush_no_valid", bus.resp_valid_o, 1'b0);
        @(negedge clk);
        check("wait_flush_core_rstn_high", bus.mul_reset_n_o, 1'b1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.resp_valid_o) seen = 1'b1;
        end
        check("wait_flush_no_resp", seen, 1'b0);
        run_op(3'b000, 32'd2, 32'd3, 2, 0, 0);

        // Flush and acceptance together in RESP: the result is dropped, core untouched.
        stub_lat = 2;
        send_req(3'b001, 32'd5, 32'd6);
        cycles = 1;
        while (!bus.resp_valid_o && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        check("resp_flush_setup", bus.resp_valid_o, 1'b1);
        bus.flush_i      = 1'b1;
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b0;
        check("resp_flush_valid_low", bus.resp_valid_o, 1'b0);
        check("resp_flush_core_rstn", bus.mul_reset_n_o, 1'b1);
        check("resp_flush_idle", bus.req_ready_o, 1'b1);

        // Core never finishes: watchdog reports an error with zero data.
        stub_hang = 1'b1;
        send_req(3'b000, 32'd3, 32'd4);
        cycles = 1;
        while (!bus.resp_valid_o && cycles < T + 50) begin
            @(negedge clk);
            cycles++;
        end
        check("timeout_valid", bus.resp_valid_o, 1'b1);
        check("timeout_err", bus.resp_err_o, 1'b1);
        check("timeout_data", bus.resp_data_o, 32'h0);
        check("timeout_latency", (cycles >= T) && (cycles <= T + 2), 1'b1);
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        check("timeout_err_cleared", bus.resp_err_o, 1'b0);
        check("timeout_valid_cleared", bus.resp_valid_o, 1'b0);
        stub_hang  = 1'b0;
        stub_clear = 1'b1;
        @(negedge clk);
        stub_clear = 1'b0;

        // Core busy for a while before the start can be issued.
        stub_ready_en = 1'b0;
        fork
            run_op(3'b010, 32'hFFFF_FFF0, 32'd77, 2, 1, 8);
            begin
                repeat (5) @(negedge clk);
                stub_ready_en = 1'b1;
            end
        join

        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   $urandom_range(1, 5), $urandom_range(0, 3), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
